// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Shared definitions for the seven-segment scan controller:
//            scan state encoding and the hex glyph table (segments a..g on
//            bits 0..6, active-high).
// Config   : none (SEG_SCAN_LZ_BLANK_EN is consumed by seg_scan_ctrl only)
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Entry N holds the glyph for hex value N (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] c_glyph_tbl = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_if
// Purpose  : Digit-write handshake between a requester and seg_scan_ctrl.
// Signals  : wr_valid - write request (held by requester until accepted)
//            wr_ready - write accept
//            wr_idx   - digit index, 0 = least significant
//            wr_data  - 4-bit digit value
// Modports : master (requester), slave (seg_scan_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic               wr_valid;
  logic               wr_ready;
  logic [c_idx_w-1:0] wr_idx;
  logic [3:0]         wr_data;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_data,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/seg_glyph_dec.sv
`default_nettype none
// ============================================================================
// Module   : seg_glyph_dec
// Purpose  : Combinational hex-to-seven-segment decoder.
// Ports    : digit - 4-bit value in
//            seg   - segments a..g on bits 0..6, active-high
// Revision : 1.0 - initial release
// ============================================================================
module seg_glyph_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = c_glyph_tbl[digit];

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Multiplexed seven-segment scan controller. Each digit is shown
//            for dwell+1 cycles, separated by BLANK_CYC dark cycles. Writes
//            land in a shadow buffer that is copied to the displayed buffer
//            at the frame boundary, so a frame never mixes old and new data.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            en         - scan enable; low forces IDLE
//            dwell      - SHOW length per digit minus one
//            wr         - digit-write handshake (slave modport)
//            seg        - segments a..g, active-high, registered
//            dig_en     - one-hot digit select, registered
//            frame_done - one-cycle pulse on the last SHOW cycle of a frame
// Config   : SEG_SCAN_LZ_BLANK_EN - when defined, leading-zero digits above
//            digit 0 are shown dark (dig_en still asserted).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_W    = 16,
  parameter int BLANK_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DWELL_W-1:0]    dwell,
  seg_scan_ctrl_if.slave        wr,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // A zero-length blank is not meaningful; clamp to one dark cycle.
  localparam int c_blk   = (BLANK_CYC < 1) ? 1 : BLANK_CYC;
  localparam int c_blk_w = $clog2(c_blk + 1);
  // One counter serves both BLANK and SHOW, so size it for the larger.
  localparam int c_cnt_w = (DWELL_W > c_blk_w) ? DWELL_W : c_blk_w;

  localparam logic [c_cnt_w-1:0] c_blk_last = c_cnt_w'(c_blk - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

  scan_state_e                r_state,  w_state_nxt;
  logic [c_cnt_w-1:0]         r_cnt,    w_cnt_nxt;
  logic [c_cnt_w-1:0]         r_dwell,  w_dwell_nxt;
  logic [c_idx_w-1:0]         r_idx,    w_idx_nxt;
  logic [6:0]                 r_seg,    w_seg_nxt;
  logic [NUM_DIGITS-1:0]      r_dig_en, w_dig_en_nxt;

  logic [NUM_DIGITS-1:0][3:0] r_shadow;
  logic [NUM_DIGITS-1:0][3:0] r_active;

  logic                       w_show_last;
  logic                       w_boundary;
  logic                       w_wr_fire;
  logic [3:0]                 w_cur_digit;
  logic [6:0]                 w_cur_glyph;
  logic                       w_lz_blank;

  // --------------------------------------------------------------------------
  // Frame boundary: last SHOW cycle of the most significant digit. The
  // shadow->active copy happens on the edge closing this cycle, so writes are
  // refused here to keep a write from racing the copy.
  // --------------------------------------------------------------------------
  assign w_show_last = (r_state == SHOW) && (r_cnt == r_dwell);
  assign w_boundary  = w_show_last && (r_idx == c_idx_last);
  assign frame_done  = w_boundary;
  assign wr.wr_ready = !w_boundary;
  assign w_wr_fire   = wr.wr_valid && wr.wr_ready;

  assign w_cur_digit = r_active[r_idx];

  seg_glyph_dec u_glyph_dec (
    .digit (w_cur_digit),
    .seg   (w_cur_glyph)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Digit idx is a leading zero when it and every higher digit are zero.
  // Digit 0 always shows so a value of zero is still visible.
  always_comb begin
    w_lz_blank = (r_idx != '0);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if ((d >= int'(r_idx)) && (r_active[d] != 4'd0)) begin
        w_lz_blank = 1'b0;
      end
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. seg/dig_en are computed one cycle
  // ahead so the registered values are valid from the first SHOW cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_dwell_nxt  = r_dwell;
    w_seg_nxt    = 7'd0;
    w_dig_en_nxt = '0;

    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end
        BLANK: begin
          if (r_cnt == c_blk_last) begin
            w_state_nxt  = SHOW;
            w_cnt_nxt    = '0;
            w_dwell_nxt  = c_cnt_w'(dwell);
            w_dig_en_nxt = NUM_DIGITS'(1) << r_idx;
            w_seg_nxt    = w_lz_blank ? 7'd0 : w_cur_glyph;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (w_show_last) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
          end else begin
            w_cnt_nxt    = r_cnt + 1'b1;
            w_dig_en_nxt = r_dig_en;
            w_seg_nxt    = r_seg;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dwell  <= '0;
      r_idx    <= '0;
      r_seg    <= 7'd0;
      r_dig_en <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dwell  <= w_dwell_nxt;
      r_idx    <= w_idx_nxt;
      r_seg    <= w_seg_nxt;
      r_dig_en <= w_dig_en_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Digit storage. An out-of-range wr_idx matches no digit and is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (w_wr_fire && (wr.wr_idx == c_idx_w'(d))) begin
          r_shadow[d] <= wr.wr_data;
        end
        if (w_boundary) begin
          r_active[d] <= r_shadow[d];
        end
      end
    end
  end

  assign seg    = r_seg;
  assign dig_en = r_dig_en;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl. Expected outputs come
//            from a slot/frame arithmetic model of the scan timeline plus
//            shadow/active digit arrays. Honours SEG_SCAN_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int DWELL_W    = 16;
  localparam int BLANK_CYC  = 2;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [DWELL_W-1:0]    dwell;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  frame_done;

  int total = 0;
  int bad   = 0;

  int m_shadow [NUM_DIGITS];
  int m_active [NUM_DIGITS];

  seg_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) wr_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .DWELL_W    (DWELL_W),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dwell      (dwell),
    .wr         (wr_if),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_glyph(input int v);
    case (v & 15)
      0:  return 7'h3F;  1:  return 7'h06;  2:  return 7'h5B;  3:  return 7'h4F;
      4:  return 7'h66;  5:  return 7'h6D;  6:  return 7'h7D;  7:  return 7'h07;
      8:  return 7'h7F;  9:  return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // True when digit i would be suppressed as a leading zero.
  function automatic bit lz_ref(input int i);
    if (!LZ || i == 0) return 1'b0;
    for (int j = i; j < NUM_DIGITS; j++) begin
      if (m_active[j] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One enabled scan cycle n (n = 0 is the first BLANK cycle after en rose):
  // compare outputs, update the model for the closing edge, then advance.
  task automatic cyc(input int n, input int d, output bit acc);
    int p, w, i;
    logic [NUM_DIGITS-1:0] e_dig;
    logic [6:0]            e_seg;
    bit                    e_fd;
    p     = BLANK_CYC + d + 1;
    w     = n % p;
    i     = (n / p) % NUM_DIGITS;
    e_fd  = (w == p - 1) && (i == NUM_DIGITS - 1);
    e_dig = '0;
    e_seg = 7'd0;
    if (w >= BLANK_CYC) begin
      e_dig = NUM_DIGITS'(1) << i;
      e_seg = lz_ref(i) ? 7'd0 : ref_glyph(m_active[i]);
    end
    chk("dig_en",     32'(dig_en),          32'(e_dig));
    chk("seg",        32'(seg),             32'(e_seg));
    chk("frame_done", 32'(frame_done),      32'(e_fd));
    chk("wr_ready",   32'(wr_if.wr_ready),  32'(!e_fd));
    if (e_fd) begin
      for (int k = 0; k < NUM_DIGITS; k++) m_active[k] = m_shadow[k];
    end
    acc = wr_if.wr_valid && !e_fd;
    if (acc && int'(wr_if.wr_idx) < NUM_DIGITS)
      m_shadow[int'(wr_if.wr_idx)] = int'(wr_if.wr_data);
    @(posedge clk); #1;
  endtask

  // One cycle with the scanner idle: everything dark, writes always accepted.
  task automatic idle_cyc();
    chk("idle_dig_en", 32'(dig_en),         32'd0);
    chk("idle_seg",    32'(seg),            32'd0);
    chk("idle_fd",     32'(frame_done),     32'd0);
    chk("idle_ready",  32'(wr_if.wr_ready), 32'd1);
    if (wr_if.wr_valid && int'(wr_if.wr_idx) < NUM_DIGITS)
      m_shadow[int'(wr_if.wr_idx)] = int'(wr_if.wr_data);
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
  endtask

  // mode 0: directed write/boundary scenario, mode 1: random writes and
  // dwell disturbance, mode 2: post-reset readback. en drops on the last cycle.
  task automatic run_phase(input int d, input int len, input int mode, input int ph);
    int  p, w;
    bit  acc;
    int  dir_val [4];
    dir_val = '{4, 7, 0, 9};
    p = BLANK_CYC + d + 1;
    dwell = DWELL_W'(d);
    en = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < len; n++) begin
      w = n % p;
      if (mode == 0) begin
        if (n >= 5 && n <= 8) begin
          wr_if.wr_valid = 1'b1;
          wr_if.wr_idx   = IDX_W'(3 - (n - 5));
          wr_if.wr_data  = 4'(dir_val[n - 5]);
        end
        if (n == 23) begin
          wr_if.wr_valid = 1'b1;
          wr_if.wr_idx   = IDX_W'(2);
          wr_if.wr_data  = 4'hE;
          chk("bnd_fd",    32'(frame_done),     32'd1);
          chk("bnd_ready", 32'(wr_if.wr_ready), 32'd0);
        end
        if (n == 24) chk("held_ready",  32'(wr_if.wr_ready), 32'd1);
        if (n == 2)  chk("f0_d0_seg",   32'(seg), 32'h3F);
        if (n == 20) chk("f0_d3_seg",   32'(seg), LZ ? 32'h00 : 32'h3F);
        if (n == 26) chk("f1_d0_nine",  32'(seg), 32'h6F);
        if (n == 32) chk("f1_d1_zero",  32'(seg), 32'h3F);
        if (n == 38) chk("f1_d2_seven", 32'(seg), 32'h07);
        if (n == 44) chk("f1_d3_four",  32'(seg), 32'h66);
        if (n == 62) chk("f2_d2_E",     32'(seg), 32'h79);
        if (n == 87) chk("drop_dig_en", 32'(dig_en), 32'b0100);
      end else if (mode == 1) begin
        // Only the value present at SHOW entry may matter.
        dwell = (w == BLANK_CYC - 1) ? DWELL_W'(d) : DWELL_W'($urandom_range(0, 15));
        if (n < NUM_DIGITS) begin
          wr_if.wr_valid = 1'b1;
          wr_if.wr_idx   = IDX_W'(n);
          wr_if.wr_data  = 4'((4 * ph + n) & 15);
        end else if (!wr_if.wr_valid && $urandom_range(0, 2) == 0) begin
          wr_if.wr_valid = 1'b1;
          wr_if.wr_idx   = IDX_W'($urandom_range(0, NUM_DIGITS - 1));
          wr_if.wr_data  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
      end else begin
        if (n == 10) chk("rst_d2_zero", 32'(seg), LZ ? 32'h00 : 32'h3F);
        if (n == 18) chk("lz_d0",       32'(seg), 32'h3F);
        if (n == 22) chk("lz_d1_five",  32'(seg), 32'h6D);
        if (n == 26) chk("lz_d2",       32'(seg), LZ ? 32'h00 : 32'h3F);
        if (n == 30) chk("lz_d3",       32'(seg), LZ ? 32'h00 : 32'h3F);
      end
      if (n == len - 1) en = 1'b0;
      cyc(n, d, acc);
      if (acc) wr_if.wr_valid = 1'b0;
    end
    dwell = DWELL_W'(d);
    idle_cyc();
    idle_cyc();
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    en    = 1'b0;
    dwell = '0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_idx   = '0;
    wr_if.wr_data  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig_en", 32'(dig_en),         32'd0);
    chk("rst_seg",    32'(seg),            32'd0);
    chk("rst_fd",     32'(frame_done),     32'd0);
    chk("rst_ready",  32'(wr_if.wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cyc();

    // Directed: dwell=3, writes mid-frame, held write at boundary, en drop
    // during SHOW of digit 2 (n=87).
    run_phase(3, 88, 0, 0);

    for (int ph = 0; ph < 6; ph++) begin
      int d, p;
      d = $urandom_range(0, 4);
      p = BLANK_CYC + d + 1;
      run_phase(d, $urandom_range(2 * NUM_DIGITS * p, 3 * NUM_DIGITS * p), 1, ph);
    end

    // Asynchronous reset in the middle of SHOW.
    dwell = DWELL_W'(2);
    en = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) cyc(n, 2, acc);
    chk("pre_rst_dig_en", 32'(dig_en), 32'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dig_en", 32'(dig_en),         32'd0);
    chk("arst_seg",    32'(seg),            32'd0);
    chk("arst_fd",     32'(frame_done),     32'd0);
    chk("arst_ready",  32'(wr_if.wr_ready), 32'd1);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cyc();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_idx   = IDX_W'(1);
    wr_if.wr_data  = 4'd5;
    idle_cyc();
    run_phase(1, 48, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits.
REQ-002 SHALL have parameter DWELL_W, default 16, width of the dwell input.
REQ-003 SHALL have parameter BLANK_CYC, default 2, dark cycles between digits (minimum 1).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port dwell  input  DWELL_W  SHOW length per digit, minus one, in cycles.
REQ-008 SHALL have port wr_valid  input  1  digit write request.
REQ-009 SHALL have port wr_ready  output  1  digit write accept.
REQ-010 SHALL have port wr_idx  input  $clog2(NUM_DIGITS)  digit index to write (0 = least significant).
REQ-011 SHALL have port wr_data  input  4  digit value, 0x0-0xF.
REQ-012 SHALL have port seg  output  7  segments a..g on bits 0..6, active-high.
REQ-013 SHALL have port dig_en  output  NUM_DIGITS  digit select, one-hot or zero, active-high.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-015 SHALL implement states IDLE, BLANK and SHOW, with a registered scan index idx.
REQ-016 In IDLE: seg=0, dig_en=0, idx=0; on en=1 SHALL go to BLANK on the next edge.
REQ-017 BLANK SHALL last exactly BLANK_CYC cycles, with dig_en=0 and seg=0, then go to SHOW.
REQ-018 SHOW SHALL sample dwell on entry and last exactly dwell+1 cycles; dwell=0 gives 1 cycle.
REQ-019 In SHOW: dig_en=1<<idx and seg=decode(active[idx]), both registered and valid from the first SHOW cycle.
REQ-020 On SHOW exit: idx SHALL advance modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0) and the state SHALL return to BLANK.
REQ-021 On exit from SHOW with idx=NUM_DIGITS-1 (frame boundary) SHALL pulse frame_done for one cycle.
REQ-022 In the same cycle as the frame boundary, SHALL copy all shadow digits into the active digits (tear-free update).
REQ-023 A write SHALL be accepted when wr_valid=1 and wr_ready=1, and SHALL update shadow[wr_idx] only.
REQ-024 wr_ready SHALL be 1 except in the frame-boundary cycle, when it is 0; a pending request is held by the requester.
REQ-025 en=0 in any state SHALL force IDLE on the next edge: idx=0, outputs dark, no frame_done; shadow and active digits kept.
REQ-026 decode SHALL map 0x0-0xF to standard hex glyphs (0-9, A, b, C, d, E, F).
REQ-027 wr_idx >= NUM_DIGITS SHALL be accepted and ignored.

Reset
REQ-028 On rst_n=0, SHALL immediately force: state=IDLE, idx=0, seg=0, dig_en=0, frame_done=0, wr_ready=1, and all shadow and active digits 0.
REQ-029 SHALL resume from IDLE on the first edge after rst_n deasserts, even if reset was asserted mid-scan.

Configuration
REQ-030 With macro SEG_SCAN_LZ_BLANK_EN defined: during SHOW of digit i>0, if active[i] and all higher active digits are 0, seg=0 and dig_en stays asserted; digit 0 is never blanked.
REQ-031 Without SEG_SCAN_LZ_BLANK_EN: every digit shows its glyph, including leading zeros.

Structure
REQ-032 Shared package seg_scan_pkg SHALL hold the state enum (IDLE/BLANK/SHOW) and the 16-entry glyph constant table.
REQ-033 decode SHALL be a sub-module seg_glyph_dec (4-bit in, 7-bit out, combinational, uses the package table).

Verification
REQ-034 Reset, en=1, dwell=3, BLANK_CYC=2: dig_en sequence 0,0,0001x4,0,0,0010x4...; frame_done pulses every 24 cycles.
REQ-035 Write {3,2,1,0}=4,7,0,9 mid-frame: no seg change until after the next frame_done; then digit0 seg=0x6F (9), digit1 seg=0x3F (0).
REQ-036 wr_valid held at the frame-boundary cycle: wr_ready=0 that cycle; write accepted the next cycle and visible after one further frame.
REQ-037 Drop en during SHOW of digit 2: next cycle dig_en=0, seg=0, no frame_done; re-enabling starts with BLANK then digit 0.
REQ-038 With SEG_SCAN_LZ_BLANK_EN and active digits {3..0}=0,0,5,0: digits 3 and 2 give seg=0; digit 1 gives 0x6D; digit 0 gives 0x3F.
REQ-039 Assert rst_n=0 asynchronously mid-SHOW: outputs go to 0 before the next clock edge; all digits read back 0 after restart.
